// File: rtl/store_buffer.sv
// Store narrowing plus a small FIFO that drains stores to data memory.
// Also flags misaligned stores and load-to-pending-store word hits.
module store_buffer #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wrEn,
  input  logic [1:0]       wrType,
  input  logic [31:0]      wrAddr,
  input  logic [31:0]      wrData,
  output logic             wrReady,
  output logic             misalign,
  output logic             memReq,
  output logic [31:0]      memAddr,
  output logic [31:0]      memWdata,
  output logic [3:0]       memByteEn,
  input  logic             memAck,
  input  logic [31:0]      ldAddr,
  output logic             ldHit,
  output logic [CNT_W-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  entry_t           ent_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt_q;

  logic        full;
  logic        empty;
  logic        bad;
  logic        push;
  logic        pop;
  logic [3:0]  nb_be;
  logic [31:0] nb_data;

  assign full  = cnt_q == CNT_W'(DEPTH);
  assign empty = cnt_q == '0;

  always_comb begin
    nb_be   = 4'b0000;
    nb_data = wrData;
    bad     = 1'b0;
    unique case (1'b1)
      (wrType == 2'b00): begin
        nb_be = 4'b1111;
        bad   = wrAddr[1:0] != 2'b00;
      end
      (wrType == 2'b01): begin
        nb_data = {2{wrData[15:0]}};
        nb_be   = wrAddr[1] ? 4'b1100 : 4'b0011;
        bad     = wrAddr[0];
      end
      (wrType == 2'b10): begin
        nb_data = {4{wrData[7:0]}};
        nb_be   = 4'b0001 << wrAddr[1:0];
      end
      default: bad = 1'b1;
    endcase
  end

  assign misalign = wrEn & bad;
  assign push     = wrEn & ~full & ~bad;
  assign pop      = ~empty & memAck;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (push) begin
        vld_q[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload needs no reset: it is only visible through vld_q / count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[wr_ptr] <= '{
        wa:   wrAddr[31:2],
        data: nb_data,
        be:   nb_be
      };
    end
  end

  always_comb begin
    ldHit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && ent_q[i].wa == ldAddr[31:2])
        ldHit = 1'b1;
    end
  end

  assign wrReady   = ~full;
  assign memReq    = ~empty;
  assign memAddr   = empty ? 32'd0 : {ent_q[rd_ptr].wa, 2'b00};
  assign memWdata  = empty ? 32'd0 : ent_q[rd_ptr].data;
  assign memByteEn = empty ? 4'd0 : ent_q[rd_ptr].be;
  assign count     = cnt_q;

  logic unused_ld;
  assign unused_ld = ^ldAddr[1:0];

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboarded random/directed bench for store_buffer.
// Reference model is a queue of narrowed stores in program order.
module tb_store_buffer;

  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             wrEn;
  logic [1:0]       wrType;
  logic [31:0]      wrAddr;
  logic [31:0]      wrData;
  logic             wrReady;
  logic             misalign;
  logic             memReq;
  logic [31:0]      memAddr;
  logic [31:0]      memWdata;
  logic [3:0]       memByteEn;
  logic             memAck;
  logic [31:0]      ldAddr;
  logic             ldHit;
  logic [CNT_W-1:0] count;

  store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wrEn(wrEn), .wrType(wrType),
    .wrAddr(wrAddr), .wrData(wrData),
    .wrReady(wrReady), .misalign(misalign),
    .memReq(memReq), .memAddr(memAddr),
    .memWdata(memWdata), .memByteEn(memByteEn),
    .memAck(memAck), .ldAddr(ldAddr),
    .ldHit(ldHit), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   armed = 0;
  logic exp_mis = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int size_of(input logic [1:0] ty);
    return (ty == 2'd0) ? 4 : (ty == 2'd1) ? 2 : 1;
  endfunction

  function automatic bit is_bad(input logic [1:0] ty, input logic [31:0] a);
    if (ty == 2'd3) return 1'b1;
    return (int'(a[1:0]) % size_of(ty)) != 0;
  endfunction

  // Lane i of memory data carries source byte (i mod size); enables cover
  // the bytes from the address offset for the access size.
  function automatic ent_t narrow(input logic [1:0] ty, input logic [31:0] a,
                                  input logic [31:0] d);
    ent_t r;
    int sz;
    int off;
    sz = size_of(ty);
    off = int'(a[1:0]);
    r.a = {a[31:2], 2'b00};
    r.be = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      r.d[8*i +: 8] = d[8*(i % sz) +: 8];
      r.be[i] = (i >= off) && (i < off + sz);
    end
    return r;
  endfunction

  task automatic step(input logic en, input logic [1:0] ty,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic [31:0] la,
                      input logic rst);
    bit   will_push;
    ent_t e;
    reset = rst; wrEn = en; wrType = ty;
    wrAddr = a; wrData = d; memAck = ack; ldAddr = la;
    exp_mis = en && is_bad(ty, a);
    will_push = en && !is_bad(ty, a) && (exp_q.size() < DEPTH);
    e = narrow(ty, a, d);
    @(posedge clk);
    #1;
    if (rst) exp_q.delete();
    else if (will_push) exp_q.push_back(e);
  endtask

  task automatic idle(input logic ack, input logic [31:0] la);
    step(1'b0, 2'd0, 32'h0, 32'h0, ack, la, 1'b0);
  endtask

  always @(negedge clk) begin
    int   n;
    logic hit;
    ent_t h;
    if (armed) begin
      n = exp_q.size();
      hit = 1'b0;
      foreach (exp_q[i]) if (exp_q[i].a[31:2] == ldAddr[31:2]) hit = 1'b1;
      chk("count", 32'(count), 32'(n));
      chk("wrReady", 32'(wrReady), 32'(n < DEPTH));
      chk("memReq", 32'(memReq), 32'(n > 0));
      chk("ldHit", 32'(ldHit), 32'(hit));
      chk("misalign", 32'(misalign), 32'(exp_mis));
      if (n > 0) begin
        h = exp_q[0];
        chk("memAddr", memAddr, h.a);
        chk("memWdata", memWdata, h.d);
        chk("memByteEn", 32'(memByteEn), 32'(h.be));
        if (memAck && memReq) void'(exp_q.pop_front());
      end else begin
        chk("memAddr_idle", memAddr, 32'h0);
        chk("memWdata_idle", memWdata, 32'h0);
        chk("memByteEn_idle", 32'(memByteEn), 32'h0);
      end
    end
  end

  logic [31:0] pool [8];

  initial begin
    pool[0] = 32'h0000_4000; pool[1] = 32'h0000_4001;
    pool[2] = 32'h0000_4002; pool[3] = 32'h0000_4003;
    pool[4] = 32'h0000_4004; pool[5] = 32'h0000_4006;
    pool[6] = 32'h0000_8008; pool[7] = 32'h0000_800B;

    reset = 1'b1; wrEn = 1'b0; wrType = 2'd0; wrAddr = '0;
    wrData = '0; memAck = 1'b0; ldAddr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    armed = 1;

    idle(1'b0, 32'h0);
    step(1'b1, 2'd0, 32'h1000, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    idle(1'b0, 32'h1000);
    idle(1'b1, 32'h1000);
    idle(1'b0, 32'h1000);

    step(1'b1, 2'd1, 32'h2002, 32'h12345678, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd2, 32'h3003, 32'h12345678, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd1, 32'h2001, 32'h12345678, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 32'h2002, 32'h12345678, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd3, 32'h2000, 32'h12345678, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);
    idle(1'b0, 32'h0);

    step(1'b1, 2'd0, 32'h10, 32'hAAAA0001, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 32'h14, 32'hAAAA0002, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 32'h18, 32'hAAAA0003, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 32'h1C, 32'hAAAA0004, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 2'd2, 32'h100 + 32'(i), 32'(i * 17 + 3), 1'b1,
           32'h104, 1'b0);
    idle(1'b1, 32'h0);
    idle(1'b1, 32'h0);
    idle(1'b0, 32'h0);

    step(1'b1, 2'd2, 32'h4001, 32'h000000A5, 1'b0, 32'h4003, 1'b0);
    idle(1'b0, 32'h4003);
    idle(1'b0, 32'h4004);
    step(1'b1, 2'd1, 32'h4006, 32'h0000BEEF, 1'b0, 32'h4004, 1'b0);
    idle(1'b0, 32'h4005);
    step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1, 32'h4003, 1'b1);
    idle(1'b0, 32'h4003);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0,
           ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
           pool[$urandom_range(0, 7)], $urandom,
           $urandom_range(0, 2) == 0,
           pool[$urandom_range(0, 7)],
           $urandom_range(0, 49) == 0);
    end

    for (int i = 0; i < 4; i++) idle(1'b1, 32'h0);
    idle(1'b0, 32'h0);
    chk("drained_count", 32'(count), 32'h0);
    chk("drained_req", 32'(memReq), 32'h0);

    armed = 0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
